// File: rtl/vga_fb_pkg.sv
// Shared types for the framebuffer arbiter: grant/tag encoding, stat width,
// and the write-queue entry layout.
package vga_fb_pkg;
  localparam int FB_AW  = 10;
  localparam int FB_DW  = 12;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_VID  = 2'd1,
    G_HR   = 2'd2,
    G_WR   = 2'd3
  } fb_grant_t;

  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [FB_DW-1:0] data;
  } wq_entry_t;
endpackage

// File: rtl/vga_fb_wq.sv
// Host write queue: synchronous FIFO with first-word-fall-through head.
// Pointers carry one extra wrap bit so full/empty come from the MSB compare.
module vga_fb_wq #(
  parameter int DEPTH = 4,
  parameter int W     = 22
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;

  assign empty = (wp == rp);
  assign full  = (wp[PW-1] != rp[PW-1]) && (wp[PW-2:0] == rp[PW-2:0]);
  assign dout  = mem[rp[PW-2:0]];

  // Storage array; contents need no reset, the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[PW-2:0]] <= din;
  end

  // Read/write pointers; reset empties the queue, discarding pending writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/vga_fb_arb.sv
// Framebuffer arbiter in front of a 1RW RAM. Priority: video read, host read,
// then write-queue drain. Optional stall counter enabled by VGA_FB_ARB_STAT_EN.
module vga_fb_arb
  import vga_fb_pkg::*;
#(
  parameter int AW       = FB_AW,
  parameter int DW       = FB_DW,
  parameter int WQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [AW-1:0]     vid_addr,
  output logic              vid_rvalid,
  output logic [DW-1:0]     vid_rdata,
  input  logic              hw_valid,
  output logic              hw_ready,
  input  logic [AW-1:0]     hw_addr,
  input  logic [DW-1:0]     hw_data,
  input  logic              hr_valid,
  output logic              hr_ready,
  input  logic [AW-1:0]     hr_addr,
  output logic              hr_rvalid,
  output logic [DW-1:0]     hr_rdata,
  output logic              ram_we,
  output logic [AW-1:0]     ram_addr,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout,
  output logic [STAT_W-1:0] stat_wq_stall
);
  wq_entry_t wr_in, wr_head;
  logic      wq_full, wq_empty, wq_push, wq_pop;
  fb_grant_t grant, tag;

  assign wr_in.addr = hw_addr;
  assign wr_in.data = hw_data;

  // Reads wait for an empty queue so they observe every earlier write.
  assign hr_ready = !vid_req && wq_empty;
  assign hw_ready = !wq_full;
  assign wq_push  = hw_valid && hw_ready;
  assign wq_pop   = (grant == G_WR);

  vga_fb_wq #(.DEPTH(WQ_DEPTH), .W($bits(wq_entry_t))) u_wq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wq_push),
    .din   (wr_in),
    .pop   (wq_pop),
    .dout  (wr_head),
    .full  (wq_full),
    .empty (wq_empty)
  );

  // Fixed-priority grant and the RAM port mux it selects.
  always_comb begin
    grant    = G_NONE;
    ram_addr = '0;
    if (vid_req)                    grant = G_VID;
    else if (hr_valid && hr_ready)  grant = G_HR;
    else if (!wq_empty)             grant = G_WR;
    case (grant)
      G_VID:   ram_addr = vid_addr;
      G_HR:    ram_addr = hr_addr;
      G_WR:    ram_addr = wr_head.addr;
      default: ram_addr = '0;
    endcase
  end

  assign ram_we  = (grant == G_WR);
  assign ram_din = wr_head.data;

  // Last-grant tag steers the 1-cycle RAM read return; reset drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag <= G_NONE;
    else        tag <= (grant == G_WR) ? G_NONE : grant;
  end

  assign vid_rvalid = (tag == G_VID);
  assign hr_rvalid  = (tag == G_HR);
  assign vid_rdata  = ram_dout;
  assign hr_rdata   = ram_dout;

`ifdef VGA_FB_ARB_STAT_EN
  logic [STAT_W-1:0] stall_cnt;

  // Saturating count of cycles a host write is held off by a full queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      stall_cnt <= '0;
    else if (hw_valid && !hw_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

  assign stat_wq_stall = stall_cnt;
`else
  assign stat_wq_stall = '0;
`endif
endmodule

// File: tb/tb_vga_fb_arb.sv
// Self-checking bench for vga_fb_arb: directed table, reset-in-flight
// sequence and randomized traffic against a queue/shadow-memory model.
module tb_vga_fb_arb;
  import vga_fb_pkg::*;
  localparam int AW = 10, DW = 12, DEPTH = 4;

  logic clk, rst_n;
  logic vid_req, vid_rvalid, hw_valid, hw_ready, hr_valid, hr_ready, hr_rvalid, ram_we;
  logic [AW-1:0] vid_addr, hw_addr, hr_addr, ram_addr;
  logic [DW-1:0] vid_rdata, hw_data, hr_rdata, ram_din, ram_dout;
  logic [STAT_W-1:0] stat_wq_stall;

  vga_fb_arb #(.AW(AW), .DW(DW), .WQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .hw_valid(hw_valid), .hw_ready(hw_ready), .hw_addr(hw_addr), .hw_data(hw_data),
    .hr_valid(hr_valid), .hr_ready(hr_ready), .hr_addr(hr_addr),
    .hr_rvalid(hr_rvalid), .hr_rdata(hr_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .stat_wq_stall(stat_wq_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with registered read, preloaded with mem[i] = i on its first clock.
  logic [DW-1:0] ram_m [1024];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram_m[i] <= DW'(i);
      ram_init <= 1'b1;
    end else begin
      if (ram_we) ram_m[ram_addr] <= ram_din;
      ram_dout <= ram_m[ram_addr];
    end
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending-write queue, shadow memory, pending returns.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t mq[$];
  int  shadow [1024];
  bit  m_vrv, m_hrv;
  int  m_vdat, m_hdat, m_stat;

  function automatic int stat_exp(input int v);
`ifdef VGA_FB_ARB_STAT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_vrv = 0; m_hrv = 0; m_stat = 0;
  endtask

  // Called at the negedge with inputs stable: check, advance model, clock.
  task automatic model_step();
    bit e_hwr, e_hrr, hr_g, e_we;
    e_hwr = mq.size() < DEPTH;
    e_hrr = !vid_req && mq.size() == 0;
    hr_g  = hr_valid && e_hrr;
    e_we  = !vid_req && !hr_g && mq.size() > 0;
    chk("m_hw_ready", 32'(hw_ready), 32'(e_hwr));
    chk("m_hr_ready", 32'(hr_ready), 32'(e_hrr));
    chk("m_ram_we", 32'(ram_we), 32'(e_we));
    if (vid_req)   chk("m_addr_vid", 32'(ram_addr), 32'(vid_addr));
    else if (hr_g) chk("m_addr_hr", 32'(ram_addr), 32'(hr_addr));
    else if (e_we) begin
      chk("m_addr_wr", 32'(ram_addr), 32'(mq[0].a));
      chk("m_din_wr", 32'(ram_din), 32'(mq[0].d));
    end
    chk("m_vid_rvalid", 32'(vid_rvalid), 32'(m_vrv));
    if (m_vrv) chk("m_vid_rdata", 32'(vid_rdata), 32'(m_vdat));
    chk("m_hr_rvalid", 32'(hr_rvalid), 32'(m_hrv));
    if (m_hrv) chk("m_hr_rdata", 32'(hr_rdata), 32'(m_hdat));
    chk("m_stat", 32'(stat_wq_stall), 32'(stat_exp(m_stat)));
    m_vrv  = vid_req;
    m_vdat = shadow[vid_addr];
    m_hrv  = hr_g;
    m_hdat = shadow[hr_addr];
    if (hw_valid && !e_hwr && m_stat < 65535) m_stat++;
    if (e_we) begin
      shadow[mq[0].a] = int'(mq[0].d);
      void'(mq.pop_front());
    end
    if (hw_valid && e_hwr) mq.push_back('{hw_addr, hw_data});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vid_req = 0; vid_addr = '0; hw_valid = 0; hw_addr = '0; hw_data = '0;
    hr_valid = 0; hr_addr = '0;
  endtask

  typedef struct {
    bit vr; logic [AW-1:0] va; bit hw; logic [AW-1:0] ha; logic [DW-1:0] hd;
    bit hr; logic [AW-1:0] hra;
    bit e_hwr, e_hrr, e_we, e_ac; logic [AW-1:0] e_addr;
    bit e_vrv, e_hrv; logic [DW-1:0] e_rd;
  } vec_t;

  function automatic vec_t mk(bit vr, int va, bit hw, int ha, int hd, bit hr, int hra,
                              bit hwr, bit hrr, bit we, bit ac, int addr,
                              bit vrv, bit hrv, int rd);
    vec_t v;
    v.vr = vr; v.va = AW'(va); v.hw = hw; v.ha = AW'(ha); v.hd = DW'(hd);
    v.hr = hr; v.hra = AW'(hra);
    v.e_hwr = hwr; v.e_hrr = hrr; v.e_we = we; v.e_ac = ac; v.e_addr = AW'(addr);
    v.e_vrv = vrv; v.e_hrv = hrv; v.e_rd = DW'(rd);
    return v;
  endfunction

  vec_t tab[19];

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = i;
    //             vr va    hw ha    hd     hr hra   | hwr hrr we ac addr  vrv hrv rd
    tab[0]  = mk(1,'h010, 0,0,0,       0,0,      1,0,0,1,'h010, 0,0,0);
    tab[1]  = mk(1,'h011, 0,0,0,       0,0,      1,0,0,1,'h011, 1,0,'h010);
    tab[2]  = mk(1,'h012, 0,0,0,       0,0,      1,0,0,1,'h012, 1,0,'h011);
    tab[3]  = mk(1,'h020, 1,'h100,'hA00,0,0,     1,0,0,1,'h020, 1,0,'h012);
    tab[4]  = mk(1,'h021, 1,'h101,'hA01,0,0,     1,0,0,1,'h021, 1,0,'h020);
    tab[5]  = mk(1,'h022, 1,'h102,'hA02,0,0,     1,0,0,1,'h022, 1,0,'h021);
    tab[6]  = mk(1,'h023, 1,'h103,'hA03,0,0,     1,0,0,1,'h023, 1,0,'h022);
    tab[7]  = mk(1,'h024, 1,'h104,'hA04,0,0,     0,0,0,1,'h024, 1,0,'h023);
    tab[8]  = mk(1,'h025, 1,'h104,'hA04,0,0,     0,0,0,1,'h025, 1,0,'h024);
    tab[9]  = mk(0,0,     1,'h104,'hA04,1,'h102, 0,0,1,1,'h100, 1,0,'h025);
    tab[10] = mk(0,0,     1,'h104,'hA04,1,'h102, 1,0,1,1,'h101, 0,0,0);
    tab[11] = mk(0,0,     0,0,0,       1,'h102,  1,0,1,1,'h102, 0,0,0);
    tab[12] = mk(0,0,     0,0,0,       1,'h102,  1,0,1,1,'h103, 0,0,0);
    tab[13] = mk(0,0,     0,0,0,       1,'h102,  1,0,1,1,'h104, 0,0,0);
    tab[14] = mk(0,0,     0,0,0,       1,'h102,  1,1,0,1,'h102, 0,0,0);
    tab[15] = mk(0,0,     0,0,0,       0,0,      1,1,0,0,0,     0,1,'hA02);
    tab[16] = mk(1,'h030, 0,0,0,       1,'h031,  1,0,0,1,'h030, 0,0,0);
    tab[17] = mk(0,0,     0,0,0,       1,'h031,  1,1,0,1,'h031, 1,0,'h030);
    tab[18] = mk(0,0,     0,0,0,       0,0,      1,1,0,0,0,     0,1,'h031);

    // Power-on reset: check reset-state outputs, including hr_ready = !vid_req.
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vid_rvalid", 32'(vid_rvalid), 0);
    chk("rst_hr_rvalid", 32'(hr_rvalid), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_hw_ready", 32'(hw_ready), 1);
    chk("rst_hr_ready_idle", 32'(hr_ready), 1);
    chk("rst_stat", 32'(stat_wq_stall), 0);
    vid_req = 1;
    #1 chk("rst_hr_ready_vid", 32'(hr_ready), 0);
    vid_req = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Directed table: video burst, write fill/stall, drain, ordered host reads.
    for (int r = 0; r < 19; r++) begin
      vid_req = tab[r].vr; vid_addr = tab[r].va;
      hw_valid = tab[r].hw; hw_addr = tab[r].ha; hw_data = tab[r].hd;
      hr_valid = tab[r].hr; hr_addr = tab[r].hra;
      @(negedge clk);
      chk($sformatf("t%0d_hw_ready", r), 32'(hw_ready), 32'(tab[r].e_hwr));
      chk($sformatf("t%0d_hr_ready", r), 32'(hr_ready), 32'(tab[r].e_hrr));
      chk($sformatf("t%0d_ram_we", r), 32'(ram_we), 32'(tab[r].e_we));
      if (tab[r].e_ac) chk($sformatf("t%0d_ram_addr", r), 32'(ram_addr), 32'(tab[r].e_addr));
      chk($sformatf("t%0d_vid_rvalid", r), 32'(vid_rvalid), 32'(tab[r].e_vrv));
      chk($sformatf("t%0d_hr_rvalid", r), 32'(hr_rvalid), 32'(tab[r].e_hrv));
      if (tab[r].e_vrv) chk($sformatf("t%0d_vid_rdata", r), 32'(vid_rdata), 32'(tab[r].e_rd));
      if (tab[r].e_hrv) chk($sformatf("t%0d_hr_rdata", r), 32'(hr_rdata), 32'(tab[r].e_rd));
      model_step();
    end
    chk("stat_after_burst", 32'(stat_wq_stall), 32'(stat_exp(3)));

    // Reset with three queued writes and a video read in flight.
    idle_inputs();
    vid_req = 1;
    for (int k = 0; k < 3; k++) begin
      vid_addr = AW'('h040 + k);
      hw_valid = 1; hw_addr = AW'('h180 + k); hw_data = DW'('h5A0 + k);
      @(negedge clk);
      model_step();
    end
    idle_inputs();
    rst_n = 0;
    #1;
    chk("mrst_vid_rvalid", 32'(vid_rvalid), 0);
    chk("mrst_ram_we", 32'(ram_we), 0);
    chk("mrst_hw_ready", 32'(hw_ready), 1);
    chk("mrst_hr_ready", 32'(hr_ready), 1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_no_we", 32'(ram_we), 0);
      chk("post_rst_no_rvalid", 32'(vid_rvalid | hr_rvalid), 0);
      model_step();
    end
    // Writes discarded by the reset must not have reached memory.
    hr_valid = 1; hr_addr = AW'('h181);
    @(negedge clk);
    model_step();
    hr_valid = 0;
    @(negedge clk);
    chk("discarded_write_absent", 32'(hr_rdata), 32'('h181));
    model_step();

    // Randomized traffic; video load alternates heavy/medium/light.
    for (int i = 0; i < 1500; i++) begin
      int pct;
      pct = (((i / 150) % 3) == 0) ? 90 : (((i / 150) % 3) == 1) ? 50 : 10;
      vid_req  = ($urandom_range(0, 99) < pct);
      vid_addr = AW'($urandom_range(0, 1023));
      hw_valid = ($urandom_range(0, 99) < 45);
      hw_addr  = AW'('h200 + $urandom_range(0, 15));
      hw_data  = DW'($urandom_range(0, 4095));
      hr_valid = ($urandom_range(0, 99) < 30);
      hr_addr  = AW'('h200 + $urandom_range(0, 15));
      @(negedge clk);
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
